// File: rtl/tactile_scan_ctrl.sv
// Tactile grid scan sequencer: row/column scan, ADC req/ack handshake, double-banked frame buffer writes.
// Optional SCAN_NOISE_FLOOR_EN adds a noise_floor input that is subtracted (saturating at 0) from each sample.
module tactile_scan_ctrl #(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16,
    parameter int ADC_W       = 12,
    parameter int ADC_TIMEOUT = 1023
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     continuous,
    input  logic [15:0]                              settle_cycles,
`ifdef SCAN_NOISE_FLOOR_EN
    input  logic [ADC_W-1:0]                         noise_floor,
`endif
    output logic [SW_WIRE_CNT-1:0]                   sw_drive,
    output logic [$clog2(RD_WIRE_CNT)-1:0]           rd_sel,
    output logic                                     adc_req,
    input  logic                                     adc_ack,
    input  logic [ADC_W-1:0]                         adc_data,
    output logic                                     wr_en,
    output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] wr_addr,
    output logic [ADC_W-1:0]                         wr_data,
    output logic                                     wr_bank,
    output logic                                     frame_done,
    output logic                                     busy,
    output logic                                     adc_err
);

    localparam int RSEL_W = $clog2(RD_WIRE_CNT);
    localparam int ROW_W  = $clog2(SW_WIRE_CNT);
    localparam int ADDR_W = $clog2(SW_WIRE_CNT * RD_WIRE_CNT);
    localparam int CONV_W = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;

    localparam logic [RSEL_W-1:0]      COL_LAST  = RSEL_W'(RD_WIRE_CNT - 1);
    localparam logic [ROW_W-1:0]       ROW_LAST  = ROW_W'(SW_WIRE_CNT - 1);
    localparam logic [CONV_W-1:0]      CONV_LAST = CONV_W'(ADC_TIMEOUT - 1);
    localparam logic [SW_WIRE_CNT-1:0] SW_FIRST  = SW_WIRE_CNT'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MUX,
        ST_CONVERT,
        ST_WRITE,
        ST_FRAME_END
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [ROW_W-1:0]        r_row, w_row_nxt;
    logic [RSEL_W-1:0]       r_col, w_col_nxt;
    logic [15:0]             r_settle, w_settle_nxt;
    logic [CONV_W-1:0]       r_conv, w_conv_nxt;
    logic [SW_WIRE_CNT-1:0]  r_sw_drive, w_sw_nxt;
    logic [ADDR_W-1:0]       r_wr_addr, w_addr_nxt;
    logic [ADC_W-1:0]        r_wr_data, w_data_nxt;
    logic                    r_adc_err, w_err_nxt;
    logic                    r_wr_bank, w_bank_nxt;
    logic                    r_adc_req;
    logic                    r_wr_en;
    logic                    r_frame_done;
    logic                    r_busy;
    logic [ADC_W-1:0]        w_sample;

`ifdef SCAN_NOISE_FLOOR_EN
    function automatic logic [ADC_W-1:0] floor_sub(input logic [ADC_W-1:0] a,
                                                   input logic [ADC_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    assign w_sample = floor_sub(adc_data, noise_floor);
`else
    assign w_sample = adc_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_settle_nxt = r_settle;
        w_conv_nxt   = r_conv;
        w_sw_nxt     = r_sw_drive;
        w_addr_nxt   = r_wr_addr;
        w_data_nxt   = r_wr_data;
        w_err_nxt    = r_adc_err;
        w_bank_nxt   = r_wr_bank;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_SETTLE;
                    w_row_nxt    = '0;
                    w_col_nxt    = '0;
                    w_settle_nxt = settle_cycles;
                    w_sw_nxt     = SW_FIRST;
                    w_addr_nxt   = '0;
                    w_err_nxt    = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (r_settle == 16'd0) begin
                    w_state_nxt = ST_CONVERT;
                    w_conv_nxt  = '0;
                end else begin
                    w_settle_nxt = r_settle - 16'd1;
                end
            end
            ST_MUX: begin
                w_state_nxt = ST_CONVERT;
                w_conv_nxt  = '0;
            end
            ST_CONVERT: begin
                // A late ack still wins over a timeout landing on the same edge.
                if (adc_ack) begin
                    w_data_nxt  = w_sample;
                    w_state_nxt = ST_WRITE;
                end else if (r_conv == CONV_LAST) begin
                    w_data_nxt  = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_conv_nxt = r_conv + CONV_W'(1);
                end
            end
            ST_WRITE: begin
                if (r_col != COL_LAST) begin
                    w_col_nxt   = r_col + RSEL_W'(1);
                    w_addr_nxt  = r_wr_addr + ADDR_W'(1);
                    w_state_nxt = ST_MUX;
                end else if (r_row != ROW_LAST) begin
                    w_row_nxt    = r_row + ROW_W'(1);
                    w_col_nxt    = '0;
                    w_sw_nxt     = r_sw_drive << 1;
                    w_settle_nxt = settle_cycles;
                    w_addr_nxt   = r_wr_addr + ADDR_W'(1);
                    w_state_nxt  = ST_SETTLE;
                end else begin
                    w_sw_nxt    = '0;
                    w_state_nxt = ST_FRAME_END;
                end
            end
            ST_FRAME_END: begin
                w_bank_nxt = ~r_wr_bank;
                if (continuous) begin
                    w_state_nxt  = ST_SETTLE;
                    w_row_nxt    = '0;
                    w_col_nxt    = '0;
                    w_settle_nxt = settle_cycles;
                    w_sw_nxt     = SW_FIRST;
                    w_addr_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sw_nxt    = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_settle     <= '0;
            r_conv       <= '0;
            r_sw_drive   <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_adc_err    <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_adc_req    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_settle     <= w_settle_nxt;
            r_conv       <= w_conv_nxt;
            r_sw_drive   <= w_sw_nxt;
            r_wr_addr    <= w_addr_nxt;
            r_wr_data    <= w_data_nxt;
            r_adc_err    <= w_err_nxt;
            r_wr_bank    <= w_bank_nxt;
            r_adc_req    <= (w_state_nxt == ST_CONVERT);
            r_wr_en      <= (w_state_nxt == ST_WRITE);
            r_frame_done <= (w_state_nxt == ST_FRAME_END);
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign sw_drive   = r_sw_drive;
    assign rd_sel     = r_col;
    assign adc_req    = r_adc_req;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_bank    = r_wr_bank;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign adc_err    = r_adc_err;

endmodule

// File: tb/tb_tactile_scan_ctrl.sv
// Randomized bench for tactile_scan_ctrl: an ADC responder plus a frame-level reference model
// (sample order, frame length formula, bank alternation, sticky error) checks every write and frame.
module tb_tactile_scan_ctrl;

    localparam int SW    = 16;
    localparam int RD    = 16;
    localparam int ADC_W = 12;
    localparam int TO    = 8;
    localparam int NPIX  = SW * RD;
    localparam int NF    = 50;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               continuous;
    logic [15:0]        settle_cycles;
    logic [SW-1:0]      sw_drive;
    logic [3:0]         rd_sel;
    logic               adc_req;
    logic               adc_ack = 1'b0;
    logic [ADC_W-1:0]   adc_data = '0;
    logic               wr_en;
    logic [7:0]         wr_addr;
    logic [ADC_W-1:0]   wr_data;
    logic               wr_bank;
    logic               frame_done;
    logic               busy;
    logic               adc_err;
`ifdef SCAN_NOISE_FLOOR_EN
    logic [ADC_W-1:0]   noise_floor;
`endif

    tactile_scan_ctrl #(
        .SW_WIRE_CNT (SW),
        .RD_WIRE_CNT (RD),
        .ADC_W       (ADC_W),
        .ADC_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .continuous    (continuous),
        .settle_cycles (settle_cycles),
`ifdef SCAN_NOISE_FLOOR_EN
        .noise_floor   (noise_floor),
`endif
        .sw_drive      (sw_drive),
        .rd_sel        (rd_sel),
        .adc_req       (adc_req),
        .adc_ack       (adc_ack),
        .adc_data      (adc_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_bank       (wr_bank),
        .frame_done    (frame_done),
        .busy          (busy),
        .adc_err       (adc_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_sample(input int v);
`ifdef SCAN_NOISE_FLOOR_EN
        return (v > NF) ? v - NF : 0;
`else
        return v;
`endif
    endfunction

    function automatic int frame_len(input int s, input int l);
        return SW * ((s + 1) + (l + 2) + (RD - 1) * (l + 3)) + 1;
    endfunction

    // Responder configuration and reference model state.
    int  ack_lat = 0;
    bit  ack_tied = 1'b0, ack_never = 1'b0, data_is_addr = 1'b0;
    int  exp_q[$];
    bit  exp_to[$];
    int  exp_addr = 0, nwr = 0, frames = 0, req_cnt = 0, gap = 0, frame_cycle = 0, v = 0;
    bit  exp_bank = 1'b0, exp_err = 1'b0, prev_busy = 1'b0, prev_fd = 1'b0, prev_wr = 1'b0, ack_now = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_to.delete();
            exp_addr = 0; nwr = 0; req_cnt = 0; gap = 0; frame_cycle = 0;
            exp_bank = 1'b0; exp_err = 1'b0;
            prev_busy = 1'b0; prev_fd = 1'b0; prev_wr = 1'b0;
            adc_ack = 1'b0;
            adc_data = '0;
        end else begin
            if (busy && (!prev_busy || prev_fd)) begin
                frame_cycle = 1;
                if (!prev_busy) exp_err = 1'b0;
            end else if (busy) begin
                frame_cycle++;
            end
            if (prev_fd) check("fd_pulse", frame_done, 0);
            if (busy && !frame_done) begin
                check("sw_onehot", sw_drive, 32'd1 << (exp_addr / RD));
                check("rd_sel", rd_sel, exp_addr % RD);
            end
            if (adc_req) begin
                req_cnt++;
                if (req_cnt == 1)
                    check("pre_req_gap", gap, (exp_addr % RD == 0) ? int'(settle_cycles) + 1 : 1);
            end else begin
                if (req_cnt > 0 && !ack_never) check("req_len", req_cnt, ack_lat + 1);
                req_cnt = 0;
            end
            if (busy && !adc_req && !wr_en && !frame_done) gap++;
            if (wr_en) begin
                check("wr_single", prev_wr, 0);
                check("wr_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    if (exp_to.pop_front()) exp_err = 1'b1;
                    check("wr_data", wr_data, exp_q.pop_front());
                end
                check("wr_addr", wr_addr, exp_addr);
                check("wr_bank", wr_bank, exp_bank);
                check("adc_err", adc_err, exp_err);
                exp_addr++;
                nwr++;
                gap = 0;
            end
            if (frame_done) begin
                check("fd_sw_zero", sw_drive, 0);
                check("fd_nwrites", nwr, NPIX);
                check("fd_bank", wr_bank, exp_bank);
                if (!ack_never)
                    check("fd_cycle", frame_cycle, frame_len(int'(settle_cycles), ack_tied ? 0 : ack_lat));
                exp_bank = ~exp_bank;
                frames++;
                exp_addr = 0;
                nwr = 0;
                gap = 0;
            end
            // ADC front end: ack lands on the (ack_lat+1)-th request cycle with fresh data.
            adc_data = ADC_W'($urandom);
            ack_now  = adc_req && !ack_never && (req_cnt == ack_lat + 1);
            adc_ack  = ack_tied || ack_now;
            if (adc_req && ack_never && req_cnt == 1) begin
                exp_q.push_back(0);
                exp_to.push_back(1'b1);
            end
            if (ack_now) begin
                v = data_is_addr ? exp_addr : int'($urandom_range(0, (1 << ADC_W) - 1));
                adc_data = ADC_W'(v);
                exp_q.push_back(exp_sample(v));
                exp_to.push_back(1'b0);
            end
            prev_busy = busy;
            prev_fd   = frame_done;
            prev_wr   = wr_en;
        end
    end

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_sw_drive"}, sw_drive, 0);
        check({pfx, "_rd_sel"}, rd_sel, 0);
        check({pfx, "_adc_req"}, adc_req, 0);
        check({pfx, "_wr_en"}, wr_en, 0);
        check({pfx, "_wr_addr"}, wr_addr, 0);
        check({pfx, "_wr_data"}, wr_data, 0);
        check({pfx, "_wr_bank"}, wr_bank, 0);
        check({pfx, "_frame_done"}, frame_done, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_adc_err"}, adc_err, 0);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("frame_count", frames, target);
    endtask

    task automatic run_frame(input int s, input int lat, input bit tied, input bit never,
                             input bit by_addr, input bit poke);
        int target;
        @(negedge clk); #1;
        settle_cycles = 16'(s);
        ack_lat       = lat;
        ack_tied      = tied;
        ack_never     = never;
        data_is_addr  = by_addr;
        target        = frames + 1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clr", adc_err, 0);
        if (poke) begin
            repeat (50) @(negedge clk);
            #1 start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        wait_frames(target, 6000);
    endtask

    initial begin
        int f0, fr_at, n;
        rst           = 1'b1;
        start         = 1'b0;
        continuous    = 1'b0;
        settle_cycles = '0;
`ifdef SCAN_NOISE_FLOOR_EN
        noise_floor   = ADC_W'(NF);
`endif
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        #1 rst = 1'b0;

        // Basic frame: ack tied high, data follows the write address.
        run_frame(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_sw", sw_drive, 0);
        check("bank_after_first", wr_bank, 1);

        // Settle of 5 with a stray start while busy.
        run_frame(5, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame($urandom_range(0, 3), 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame($urandom_range(0, 3), $urandom_range(0, 6), 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout frame, then sticky error until the next accepted start.
        run_frame(1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", adc_err, 1);
        run_frame($urandom_range(0, 2), 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous frames, reset at sample 100 of the third frame.
        @(negedge clk); #1;
        settle_cycles = '0;
        ack_lat       = $urandom_range(0, 2);
        ack_tied      = 1'b0;
        ack_never     = 1'b0;
        data_is_addr  = 1'b0;
        continuous    = 1'b1;
        start         = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        f0 = frames;
        n  = 0;
        while (!(frames == f0 + 2 && nwr == 100) && n < 12000) begin
            @(negedge clk); #1;
            n++;
        end
        check("cont_frames", frames - f0, 2);
        check("cont_sample", nwr, 100);
        check("cont_bank_f3", wr_bank, 0);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        fr_at      = frames;
        continuous = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("no_fd_after_rst", frames, fr_at);
        check("post_rst_busy", busy, 0);
        check("post_rst_bank", wr_bank, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tactile_scan_ctrl.md
Name: tactile_scan_ctrl

Overview:
- Sequencer for the tactile sensor grid; scans all SW_WIRE_CNT x RD_WIRE_CNT crossings once per frame.
- Drives one switch wire at a time and steps the read-wire mux across each row.
- Runs a req/ack handshake with the ADC front end.
- Writes each sample into a double-banked frame buffer; downstream centroid and motion_tracking logic reads the idle bank.

Parameters:
- SW_WIRE_CNT, 16, number of switch (drive) wires = rows.
- RD_WIRE_CNT, 16, number of read (sense) wires = columns.
- ADC_W, 12, ADC sample width.
- ADC_TIMEOUT, 1023, max cycles to wait for adc_ack.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- continuous  in  1  sampled in FRAME_END; 1 = rescan immediately.
- settle_cycles  in  16  extra settle cycles after each row change.
- sw_drive  out  SW_WIRE_CNT  one-hot switch-wire enable.
- rd_sel  out  $clog2(RD_WIRE_CNT)  read-wire mux select.
- adc_req  out  1  conversion request.
- adc_ack  in  1  conversion done; adc_data valid in the same cycle.
- adc_data  in  ADC_W  sample.
- wr_en  out  1  frame buffer write strobe.
- wr_addr  out  $clog2(SW_WIRE_CNT*RD_WIRE_CNT)  write address = row*RD_WIRE_CNT+col.
- wr_data  out  ADC_W  sample written.
- wr_bank  out  1  bank being written; the reader uses ~wr_bank.
- frame_done  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high in every state except IDLE.
- adc_err  out  1  sticky timeout flag; cleared when start is accepted.

Behaviour:
- Reset (asynchronous): state IDLE, row/col/timer 0; every output 0, including wr_bank = 0.
- States: IDLE, SETTLE, MUX, CONVERT, WRITE, FRAME_END. All outputs are registered.
- IDLE → SETTLE: when start=1. On this transition: row=0, col=0, sw_drive=1<<0, rd_sel=0, timer=settle_cycles, adc_err cleared.
- start while busy: ignored.
- SETTLE: lasts settle_cycles+1 cycles, then → CONVERT. No mux-settle cycle is needed here because rd_sel was updated together with sw_drive.
- MUX: one cycle after a column change, so the new rd_sel settles; then → CONVERT.
- CONVERT:
  - adc_req=1 from the first CONVERT cycle.
  - On the edge where adc_ack=1: capture adc_data, deassert adc_req, → WRITE. If ack is already high in the first CONVERT cycle, CONVERT lasts 1 cycle.
  - If ack has not arrived after ADC_TIMEOUT cycles: capture 0, set adc_err, → WRITE.
  - adc_ack outside CONVERT: ignored.
- WRITE: wr_en=1 for exactly one cycle, with wr_addr and wr_data valid. Next state:
  - col<RD_WIRE_CNT-1: col+1, rd_sel+1 → MUX.
  - else row<SW_WIRE_CNT-1: row+1, col=0, sw_drive shifted left 1, rd_sel=0, timer reloaded → SETTLE.
  - else → FRAME_END.
- FRAME_END: one cycle; frame_done=1, sw_drive=0, wr_bank toggles at exit.
  - continuous=1 → SETTLE at row 0, col 0.
  - else → IDLE.
  - Clearing continuous mid-frame lets the current frame finish.
- sw_drive: exactly one bit set in SETTLE/MUX/CONVERT/WRITE; zero in IDLE and FRAME_END.
- Timing, with ack delay L per sample and S=settle_cycles:
  - Row time = (S+1) + (L+2) + (RD_WIRE_CNT-1)*(L+3).
  - Frame = SW_WIRE_CNT * row time, followed by the FRAME_END cycle.
- Reset mid-frame: immediate return to IDLE; no frame_done and no partial wr_en; bank returns to 0.

Optional Feature:
- Macro: SCAN_NOISE_FLOOR_EN.
- Defined:
  - Adds input noise_floor [ADC_W-1:0].
  - wr_data = adc_data - noise_floor, saturating at 0 (no wrap).
  - A timeout sample still writes 0.
- Undefined: the port is absent and wr_data = captured adc_data.

Test Plan:
- Basic frame. Setup: SW=RD=16, S=0, adc_ack tied 1, adc_data=wr_addr[7:0]. Stimulus: pulse start. Expect:
  - 256 wr_en pulses, addresses 0..255 in order, wr_data = address.
  - frame_done high in the 769th cycle after the start-sampling edge.
  - wr_bank 0→1 after FRAME_END; busy low afterwards.
- Settle and one-hot. Setup: S=5. Expect:
  - Each row holds sw_drive one-hot for 6 SETTLE cycles before the first adc_req.
  - sw_drive steps 0x0001→0x8000 across rows; frame length 16*(6+2+45) = 848 cycles.
- Handshake delay. Setup: ack delayed 3 cycles per request. Expect:
  - adc_req held exactly 4 cycles per sample, then drops.
  - Data captured on the ack edge; no duplicate wr_en.
- Timeout. Setup: ADC_TIMEOUT=8, ack never asserted. Expect:
  - Every sample writes 0.
  - adc_err=1 from the first timeout until the next accepted start.
- Continuous with mid-frame reset. Setup: continuous=1. Expect:
  - Back-to-back frames alternate wr_bank 0,1,0.
  - rst asserted at sample 100 of frame 3: all outputs 0 immediately, no frame_done, wr_bank=0.
- SCAN_NOISE_FLOOR_EN. Setup: noise_floor=50. Expect:
  - adc_data=200 writes 150.
  - adc_data=30 writes 0.
